hv_mem_ctrl: RTL and testbench
==============================

# hv_mem_ctrl

Sequencing and arbitration controller for the 8-entry associative-memory hypervector store (`memory_wrapper`) in the HDC sensor-fusion datapath. It shares the store's single address/write port between a class-HV writer (training/encoder side) and an AM-search reader, using round-robin arbitration. After reset or on request, it zero-initialises every entry. It tracks per-entry occupancy and returns registered read data with a fixed latency.

## Interface
Parameters:
- `HV_DIM`, default `` `HV_DIMENSION ``: hypervector width.
- `DEPTH`, default 8: number of entries.
- `ADDR_W`, default 3: address width, equal to clog2(`DEPTH`).

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, **synchronous, active-high**.
- `clear`, input, 1: one-cycle pulse that re-runs zero-initialisation.
- `busy`, output, 1: high while the INIT sweep is in progress.
- `entry_valid`, output, `DEPTH`: per-entry bit, set when the entry has been written since the last INIT.
- `wr_valid`, input, 1: write request.
- `wr_ready`, output, 1: write grant.
- `wr_addr`, input, `ADDR_W`: write address.
- `wr_data`, input, `HV_DIM`: write data.
- `rd_req`, input, 1: read request.
- `rd_gnt`, output, 1: read grant.
- `rd_addr`, input, `ADDR_W`: read address.
- `rd_valid`, output, 1: one-cycle response strobe.
- `rd_data`, output, `HV_DIM`: registered read data.
- `rd_err`, output, 1: qualifies `rd_valid`; the entry read was not valid.
- `mem_addr`, output, `ADDR_W`: memory address.
- `mem_din`, output, `HV_DIM`: memory write data.
- `mem_we`, output, 1: SRAM write-enable-bar. 0 = write, 1 = read/idle.
- `mem_dout`, input, `HV_DIM`: memory read data.

## Operation
- **FSM states:**
  - INIT: sweeps a counter 0..`DEPTH`-1, writing all-zero data with `mem_we`=0.
  - RUN: normal arbitrated service.
- **FSM transitions:**
  - `rst` leads to INIT with counter 0.
  - INIT with counter = `DEPTH`-1 leads to RUN.
  - `clear` in RUN leads to INIT with counter 0.
  - `clear` in INIT restarts the counter at 0.
  - `rst` has priority over `clear`.
- **Outputs in INIT:**
  - `busy` = 1.
  - `wr_ready` = 0 and `rd_gnt` = 0.
  - `entry_valid` is cleared to 0 on entry.
- **Arbitration in RUN** uses a single priority bit `prio` (WR or RD); reset value is WR.
  - Write request only: grant the write.
  - Read request only: grant the read.
  - Both requesting: grant the requester `prio` points to.
  - After any grant, `prio` points to the other requester.
- **Grant signals:**
  - `wr_ready` and `rd_gnt` are combinational from the request inputs, state and `prio`.
  - At most one grant per cycle.
  - A transfer occurs when request and grant are both high.
- **Memory drive (combinational):**
  - Write grant: `mem_addr` = `wr_addr`, `mem_din` = `wr_data`, `mem_we` = 0.
  - Read grant: `mem_addr` = `rd_addr`, `mem_we` = 1.
  - Idle: `mem_we` = 1, `mem_addr` = 0, `mem_din` = 0.
- **Occupancy:** a granted write sets `entry_valid[wr_addr]` at the next edge.
- **Read error:** `rd_err` equals `!entry_valid[rd_addr]`, sampled in the grant cycle and pipelined alongside the read.
- **Request stability:** requesters hold address and data stable while their request is high and ungranted; the controller does not latch ungranted requests.

## Timing
- **Reset values:**
  - `busy` = 1 (INIT).
  - `entry_valid` = 0.
  - `rd_valid` = 0, `rd_err` = 0, `rd_data` = 0.
  - `mem_we` = 1 during the `rst` cycle.
- **INIT duration:** exactly `DEPTH` cycles (8). The first RUN cycle is the 9th cycle after `rst` deasserts.
- **Write:** granted in cycle N, so the SRAM is written at the end of N.
- **Read latency 2:**
  - Grant in cycle N.
  - `mem_dout` is valid in N+1 and is registered.
  - `rd_valid`, `rd_data` and `rd_err` are presented in N+2, for one cycle.
  - `rd_data` holds its value until the next response.
- **Back-to-back reads:** one response per cycle.
- **Write then read, same address:** write in N and read granted in N+1 returns the new data in N+3.
- **`clear` mid-read:** read responses already in flight still complete.
- **`rst` mid-read:** the read pipeline is flushed and `rd_valid` is forced to 0.
- **Responses:** `rd_valid` has no backpressure.

## Structure
- Shared package `hv_mem_pkg` holds:
  - `DEPTH` and `ADDR_W` localparams.
  - The state enum `typedef enum logic {INIT, RUN} mem_ctrl_state_t`.
  - The priority enum `typedef enum logic {PRIO_WR, PRIO_RD} mem_prio_t`.
- `HV_DIM` comes from `const.vh`.
- One sub-module, `rr_arb2`: a 2-requester round-robin arbiter with enable, taking the request pair and `prio` and producing a one-hot grant. Everything else is flat.

## Test plan
- **Reset/INIT:**
  - Stimulus: deassert `rst`.
  - Required: `mem_we` = 0 with `mem_addr` 0..7 and `mem_din` = 0 over 8 cycles; then `busy` falls and `entry_valid` = 8'h00.
- **Write/read:**
  - Stimulus: write pattern A5.. to address 3, then read address 3.
  - Required: `rd_valid` 2 cycles after the grant, `rd_data` = pattern, `rd_err` = 0, `entry_valid` = 8'h08.
- **Unwritten read:**
  - Stimulus: read address 6 after INIT.
  - Required: `rd_data` = 0 and `rd_err` = 1.
- **Contention:**
  - Stimulus: hold `wr_valid` and `rd_req` high for 4 cycles from reset-exit.
  - Required: grants W, R, W, R; no cycle with both grants.
- **Clear mid-traffic:**
  - Stimulus: pulse `clear` the cycle after a read grant.
  - Required: that read's response still arrives; 8 INIT cycles follow with no grants; `entry_valid` = 0 after INIT.
- **Reset mid-read:**
  - Stimulus: assert `rst` in the cycle after a read grant.
  - Required: no `rd_valid`; INIT restarts at address 0.

Source files
------------

// File: rtl/hv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hv_mem_pkg
// Brief    : Shared types and sizing for the hypervector store controller.
// Revision : 1.0
// ============================================================================
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

package hv_mem_pkg;
    localparam int HV_DIM_DFLT = `HV_DIMENSION;
    localparam int DEPTH       = 8;
    localparam int ADDR_W      = $clog2(DEPTH);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} mem_ctrl_state_t;
    typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} mem_prio_t;
endpackage
`default_nettype wire

// File: rtl/hv_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : hv_mem_if
// Brief    : Writer/reader request channels of the hypervector store.
// Revision : 1.0
// ============================================================================
interface hv_mem_if #(
    parameter int HV_DIM = hv_mem_pkg::HV_DIM_DFLT,
    parameter int ADDR_W = hv_mem_pkg::ADDR_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [HV_DIM-1:0] wr_data;
    logic              rd_req;
    logic              rd_gnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [HV_DIM-1:0] rd_data;
    logic              rd_err;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ready, rd_gnt, rd_valid, rd_data, rd_err
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ready, rd_gnt, rd_valid, rd_data, rd_err
    );
endinterface
`default_nettype wire

// File: rtl/hv_mem_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter with enable; one-hot grant.
// Revision : 1.0
// ============================================================================
module rr_arb2
    import hv_mem_pkg::*;
(
    input  wire        i_en,
    input  wire  [1:0] i_req,   // [0] = writer, [1] = reader
    input  wire        i_prio,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (i_prio == PRIO_WR) ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/hv_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hv_mem_ctrl
// Brief    : Zero-init sweep, round-robin port sharing and read pipeline
//            for the associative-memory hypervector store.
// Revision : 1.0
// ============================================================================
module hv_mem_ctrl #(
    parameter int HV_DIM = hv_mem_pkg::HV_DIM_DFLT,
    parameter int DEPTH  = hv_mem_pkg::DEPTH,
    parameter int ADDR_W = hv_mem_pkg::ADDR_W
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               clear,
    output logic              busy,
    output logic [DEPTH-1:0]  entry_valid,
    hv_mem_if.slave           bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [HV_DIM-1:0] mem_din,
    output logic              mem_we,
    input  wire  [HV_DIM-1:0] mem_dout
);
    import hv_mem_pkg::*;

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    mem_ctrl_state_t   r_state;
    mem_ctrl_state_t   w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    mem_prio_t         r_prio;
    logic [1:0]        w_gnt;
    logic [DEPTH-1:0]  r_entry_valid;
    logic              r_rd_p1;
    logic              r_err_p1;
    logic              r_rd_valid;
    logic              r_rd_err;
    logic [HV_DIM-1:0] r_rd_data;

    // Grants are suppressed during the reset cycle so the SRAM stays idle.
    rr_arb2 u_arb (
        .i_en   (r_state == RUN && !rst),
        .i_req  ({bus.rd_req, bus.wr_valid}),
        .i_prio (r_prio),
        .o_gnt  (w_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == INIT) begin
            if (clear) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == C_LAST) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (clear) begin
            w_state_nxt = INIT;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_prio  <= PRIO_WR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_gnt[0])
                r_prio <= PRIO_RD;
            else if (w_gnt[1])
                r_prio <= PRIO_WR;
        end
    end

    // Occupancy drops the moment INIT is (re)entered, not at the end of it.
    always_ff @(posedge clk) begin
        if (rst || w_state_nxt == INIT)
            r_entry_valid <= '0;
        else if (w_gnt[0])
            r_entry_valid[bus.wr_addr] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_p1    <= 1'b0;
            r_err_p1   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_p1    <= w_gnt[1];
            r_err_p1   <= !r_entry_valid[bus.rd_addr];
            r_rd_valid <= r_rd_p1;
            r_rd_err   <= r_rd_p1 & r_err_p1;
            if (r_rd_p1)
                r_rd_data <= mem_dout;
        end
    end

    always_comb begin
        mem_we   = 1'b1;
        mem_addr = '0;
        mem_din  = '0;
        if (rst) begin
            mem_we = 1'b1;
        end else if (r_state == INIT) begin
            mem_we   = 1'b0;
            mem_addr = r_cnt;
        end else if (w_gnt[0]) begin
            mem_we   = 1'b0;
            mem_addr = bus.wr_addr;
            mem_din  = bus.wr_data;
        end else if (w_gnt[1]) begin
            mem_addr = bus.rd_addr;
        end
    end

    assign busy         = rst || (r_state == INIT);
    assign entry_valid  = r_entry_valid;
    assign bus.wr_ready = w_gnt[0];
    assign bus.rd_gnt   = w_gnt[1];
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_err   = r_rd_err;
    assign bus.rd_data  = r_rd_data;
endmodule
`default_nettype wire

// File: tb/tb_hv_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hv_mem_ctrl
// Brief    : Directed self-checking bench for hv_mem_ctrl with an SRAM model.
// Revision : 1.0
// ============================================================================
module tb_hv_mem_ctrl;
    localparam int HV = 64;
    localparam logic [HV-1:0] PAT_A = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [HV-1:0] PAT_B = 64'h0123_4567_89AB_CDEF;
    localparam logic [HV-1:0] PAT_C = 64'hDEAD_BEEF_0BAD_F00D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          busy;
    logic [7:0]    entry_valid;
    logic [2:0]    mem_addr;
    logic [HV-1:0] mem_din;
    logic          mem_we;
    logic [HV-1:0] mem_dout;
    logic [HV-1:0] mem_arr [8];

    int n_vec = 0;
    int n_bad = 0;

    hv_mem_if #(.HV_DIM(HV), .ADDR_W(3)) bus ();

    hv_mem_ctrl #(.HV_DIM(HV), .DEPTH(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .busy        (busy),
        .entry_valid (entry_valid),
        .bus         (bus.slave),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM, active-low write enable, one-cycle read.
    always @(posedge clk) begin
        if (!mem_we) mem_arr[mem_addr] <= mem_din;
        mem_dout <= mem_arr[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; idle_reqs();
        tick(); tick(); #1;
        n_vec++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_mem_we got=%0b exp=1", mem_we); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        n_vec++; if (entry_valid !== 8'h00) begin n_bad++; $display("FAIL rst_entry_valid got=%h exp=00", entry_valid); end
        n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0) begin n_bad++; $display("FAIL rst_rd_flags got=%0b%0b exp=00", bus.rd_valid, bus.rd_err); end
        n_vec++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL rst_rd_data got=%h exp=0", bus.rd_data); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            #1;
            n_vec++; if (mem_we !== 1'b0 || mem_addr !== 3'(i) || mem_din !== '0)
                begin n_bad++; $display("FAIL init_sweep[%0d] got we=%0b addr=%0d din=%h exp we=0 addr=%0d din=0", i, mem_we, mem_addr, mem_din, i); end
            n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL init_busy[%0d] got=%0b exp=1", i, busy); end
        end
        tick(); #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL run_busy got=%0b exp=0", busy); end
        n_vec++; if (entry_valid !== 8'h00) begin n_bad++; $display("FAIL run_entry_valid got=%h exp=00", entry_valid); end
    endtask

    task automatic test_write_read;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = PAT_A; #1;
        n_vec++; if (bus.wr_ready !== 1'b1 || bus.rd_gnt !== 1'b0) begin n_bad++; $display("FAIL wr_grant got=%0b%0b exp=10", bus.wr_ready, bus.rd_gnt); end
        n_vec++; if (mem_we !== 1'b0 || mem_addr !== 3'd3 || mem_din !== PAT_A)
            begin n_bad++; $display("FAIL wr_mem got we=%0b addr=%0d din=%h exp we=0 addr=3 din=%h", mem_we, mem_addr, mem_din, PAT_A); end
        tick();
        bus.wr_valid = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 3'd3; #1;
        n_vec++; if (bus.rd_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 3'd3)
            begin n_bad++; $display("FAIL rd_grant got gnt=%0b we=%0b addr=%0d exp gnt=1 we=1 addr=3", bus.rd_gnt, mem_we, mem_addr); end
        n_vec++; if (entry_valid !== 8'h08) begin n_bad++; $display("FAIL wr_entry_valid got=%h exp=08", entry_valid); end
        tick(); bus.rd_req = 1'b0; #1;
        n_vec++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early got=%0b exp=0", bus.rd_valid); end
        tick(); #1;
        n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== PAT_A || bus.rd_err !== 1'b0)
            begin n_bad++; $display("FAIL rd_resp got v=%0b d=%h e=%0b exp v=1 d=%h e=0", bus.rd_valid, bus.rd_data, bus.rd_err, PAT_A); end
        tick(); #1;
        n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== PAT_A)
            begin n_bad++; $display("FAIL rd_hold got v=%0b d=%h exp v=0 d=%h", bus.rd_valid, bus.rd_data, PAT_A); end
    endtask

    task automatic test_unwritten;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd6; #1;
        n_vec++; if (bus.rd_gnt !== 1'b1) begin n_bad++; $display("FAIL unwr_grant got=%0b exp=1", bus.rd_gnt); end
        tick(); bus.rd_req = 1'b0;
        tick(); #1;
        n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0 || bus.rd_err !== 1'b1)
            begin n_bad++; $display("FAIL unwr_resp got v=%0b d=%h e=%0b exp v=1 d=0 e=1", bus.rd_valid, bus.rd_data, bus.rd_err); end
    endtask

    task automatic test_back_to_back;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd3; #1;
        n_vec++; if (bus.rd_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_grant0 got=%0b exp=1", bus.rd_gnt); end
        tick(); bus.rd_addr = 3'd6; #1;
        n_vec++; if (bus.rd_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_grant1 got=%0b exp=1", bus.rd_gnt); end
        tick(); bus.rd_req = 1'b0; #1;
        n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== PAT_A || bus.rd_err !== 1'b0)
            begin n_bad++; $display("FAIL b2b_resp0 got v=%0b d=%h e=%0b exp v=1 d=%h e=0", bus.rd_valid, bus.rd_data, bus.rd_err, PAT_A); end
        tick(); #1;
        n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0 || bus.rd_err !== 1'b1)
            begin n_bad++; $display("FAIL b2b_resp1 got v=%0b d=%h e=%0b exp v=1 d=0 e=1", bus.rd_valid, bus.rd_data, bus.rd_err); end
        tick(); #1;
        n_vec++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got=%0b exp=0", bus.rd_valid); end
    endtask

    task automatic test_contention;
        rst = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = PAT_B;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd2;
        tick(); tick(); #1;
        n_vec++; if (bus.wr_ready !== 1'b0 || bus.rd_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_rst_grants got=%0b%0b exp=00", bus.wr_ready, bus.rd_gnt); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            #1;
            n_vec++; if (bus.wr_ready !== 1'b0 || bus.rd_gnt !== 1'b0)
                begin n_bad++; $display("FAIL cont_init_grants[%0d] got=%0b%0b exp=00", i, bus.wr_ready, bus.rd_gnt); end
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            n_vec++; if (bus.wr_ready !== ((j % 2) == 0) || bus.rd_gnt !== ((j % 2) == 1))
                begin n_bad++; $display("FAIL cont_grant[%0d] got wr=%0b rd=%0b exp wr=%0b rd=%0b", j, bus.wr_ready, bus.rd_gnt, (j % 2) == 0, (j % 2) == 1); end
        end
        tick(); idle_reqs(); #1;
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 3'd0 || mem_din !== '0)
            begin n_bad++; $display("FAIL cont_idle got we=%0b addr=%0d din=%h exp we=1 addr=0 din=0", mem_we, mem_addr, mem_din); end
        tick(); tick(); tick();
    endtask

    task automatic test_clear_mid_read;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = PAT_C; #1;
        n_vec++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL clr_wr_grant got=%0b exp=1", bus.wr_ready); end
        tick();
        bus.wr_valid = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 3'd5; #1;
        n_vec++; if (bus.rd_gnt !== 1'b1 || entry_valid !== 8'h22)
            begin n_bad++; $display("FAIL clr_rd_grant got gnt=%0b ev=%h exp gnt=1 ev=22", bus.rd_gnt, entry_valid); end
        tick();
        bus.rd_req = 1'b0; clear = 1'b1; #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_pulse_busy got=%0b exp=0", busy); end
        tick();
        clear = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = PAT_A;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd5; #1;
        n_vec++; if (busy !== 1'b1 || entry_valid !== 8'h00)
            begin n_bad++; $display("FAIL clr_init_entry got busy=%0b ev=%h exp busy=1 ev=00", busy, entry_valid); end
        n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== PAT_C || bus.rd_err !== 1'b0)
            begin n_bad++; $display("FAIL clr_inflight got v=%0b d=%h e=%0b exp v=1 d=%h e=0", bus.rd_valid, bus.rd_data, bus.rd_err, PAT_C); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin tick(); #1; end
            n_vec++; if (bus.wr_ready !== 1'b0 || bus.rd_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 3'(i))
                begin n_bad++; $display("FAIL clr_init[%0d] got gnt=%0b%0b we=%0b addr=%0d exp gnt=00 we=0 addr=%0d", i, bus.wr_ready, bus.rd_gnt, mem_we, mem_addr, i); end
        end
        tick(); #1;
        n_vec++; if (busy !== 1'b0 || entry_valid !== 8'h00)
            begin n_bad++; $display("FAIL clr_run got busy=%0b ev=%h exp busy=0 ev=00", busy, entry_valid); end
        n_vec++; if (bus.wr_ready !== 1'b1 || bus.rd_gnt !== 1'b0)
            begin n_bad++; $display("FAIL clr_run_grant got=%0b%0b exp=10", bus.wr_ready, bus.rd_gnt); end
        tick(); idle_reqs(); #1;
        n_vec++; if (entry_valid !== 8'h80) begin n_bad++; $display("FAIL clr_post_write got=%h exp=80", entry_valid); end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_read;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd7; #1;
        n_vec++; if (bus.rd_gnt !== 1'b1) begin n_bad++; $display("FAIL rmr_grant got=%0b exp=1", bus.rd_gnt); end
        tick();
        bus.rd_req = 1'b0; rst = 1'b1; #1;
        n_vec++; if (mem_we !== 1'b1 || bus.rd_gnt !== 1'b0)
            begin n_bad++; $display("FAIL rmr_rst_cycle got we=%0b gnt=%0b exp we=1 gnt=0", mem_we, bus.rd_gnt); end
        tick();
        rst = 1'b0; #1;
        n_vec++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL rmr_flush0 got=%0b exp=0", bus.rd_valid); end
        n_vec++; if (busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 3'd0 || entry_valid !== 8'h00)
            begin n_bad++; $display("FAIL rmr_init0 got busy=%0b we=%0b addr=%0d ev=%h exp 1 0 0 00", busy, mem_we, mem_addr, entry_valid); end
        tick(); #1;
        n_vec++; if (bus.rd_valid !== 1'b0 || mem_addr !== 3'd1)
            begin n_bad++; $display("FAIL rmr_init1 got v=%0b addr=%0d exp v=0 addr=1", bus.rd_valid, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unwritten();
        test_back_to_back();
        test_contention();
        test_clear_mid_read();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
